collision_scheduler: RTL and testbench

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/collision_scheduler_if.sv | 42 ++++
 rtl/collision_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_collision_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_scheduler_if.sv
// collision_scheduler_if
//   Groups the frame-check request, positions and results of
//   collision_scheduler into one bundle.
//   master : requester side (drives start/positions, reads results)
//   slave  : the scheduler itself
//   Signals:
//     start          frame check request (pulse or level)
//     p_x, p_y       pacman position, unsigned pixels
//     m_x_all/m_y_all ghost positions, ghost i in bits [9i+8:9i]
//     m_active       bit i set = ghost i participates
//     busy           check in progress
//     done           one-cycle pulse when results update
//     hit            per-ghost collision flags of the last completed check
//     any_hit        OR of hit
//     first_hit_idx  lowest index with hit set, 0 when none
interface collision_scheduler_if #(
    parameter int unsigned NUM_GHOSTS = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_GHOSTS);

    logic                      start;
    logic [8:0]                p_x;
    logic [8:0]                p_y;
    logic [9*NUM_GHOSTS-1:0]   m_x_all;
    logic [9*NUM_GHOSTS-1:0]   m_y_all;
    logic [NUM_GHOSTS-1:0]     m_active;
    logic                      busy;
    logic                      done;
    logic [NUM_GHOSTS-1:0]     hit;
    logic                      any_hit;
    logic [IDX_W-1:0]          first_hit_idx;

    modport master (
        output start, p_x, p_y, m_x_all, m_y_all, m_active,
        input  busy, done, hit, any_hit, first_hit_idx
    );

    modport slave (
        input  start, p_x, p_y, m_x_all, m_y_all, m_active,
        output busy, done, hit, any_hit, first_hit_idx
    );
endinterface

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Checks pacman against NUM_GHOSTS ghosts per frame by time-multiplexing
//   one 2-stage squared-distance pipeline, one ghost issued per cycle.
//   A check accepted at edge T0 snapshots all inputs, issues ghost i at
//   T0+1+i, and publishes hit/any_hit/first_hit_idx with a one-cycle done
//   pulse at T0+NUM_GHOSTS+3. Inactive ghosts still use their slot.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    collision_scheduler_if.slave (request, positions, results)
module collision_scheduler #(
    parameter int unsigned NUM_GHOSTS = 4,
    parameter int unsigned RADIUS_SQ  = 144
) (
    input  logic                  clk,
    input  logic                  rst_n,
    collision_scheduler_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NUM_GHOSTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    accept;
    logic                    issue;
    logic                    retire_last;

    // Input snapshot taken on the accepting edge
    logic [8:0]              snap_px_q, snap_py_q;
    logic [9*NUM_GHOSTS-1:0] snap_mx_q, snap_my_q;
    logic [NUM_GHOSTS-1:0]   snap_act_q;

    // Stage 1: absolute coordinate differences
    logic signed [9:0]       dx, dy;
    logic [8:0]              adx, ady;
    logic                    s1_vld_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic                    s1_act_q;
    logic [8:0]              s1_adx_q, s1_ady_q;

    // Stage 2: squared distance
    logic [18:0]             sum_d;
    logic                    s2_vld_q;
    logic [IDX_W-1:0]        s2_idx_q;
    logic                    s2_act_q;
    logic [18:0]             s2_sum_q;
    logic                    s2_hit;

    // Shadow accumulator and published results
    logic [NUM_GHOSTS-1:0]   shadow_q;
    logic [IDX_W-1:0]        first_d;
    logic                    found;
    logic                    busy_q, done_q, any_hit_q;
    logic [NUM_GHOSTS-1:0]   hit_q;
    logic [IDX_W-1:0]        first_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign retire_last = s2_vld_q && (s2_idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (retire_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_px_q  <= '0;
            snap_py_q  <= '0;
            snap_mx_q  <= '0;
            snap_my_q  <= '0;
            snap_act_q <= '0;
        end else if (accept) begin
            snap_px_q  <= bus.p_x;
            snap_py_q  <= bus.p_y;
            snap_mx_q  <= bus.m_x_all;
            snap_my_q  <= bus.m_y_all;
            snap_act_q <= bus.m_active;
        end
    end

    // ------------------------------------------------------------------
    // Distance pipeline
    // ------------------------------------------------------------------
    always_comb begin
        // Zero-extended to 10 bits so the difference never wraps
        dx  = $signed({1'b0, snap_px_q}) - $signed({1'b0, snap_mx_q[9*32'(cnt_q) +: 9]});
        dy  = $signed({1'b0, snap_py_q}) - $signed({1'b0, snap_my_q[9*32'(cnt_q) +: 9]});
        adx = dx[9] ? 9'(-dx) : dx[8:0];
        ady = dy[9] ? 9'(-dy) : dy[8:0];
    end

    // 511^2 * 2 fits in 19 bits, so no truncation
    assign sum_d  = 19'(s1_adx_q) * 19'(s1_adx_q) + 19'(s1_ady_q) * 19'(s1_ady_q);
    assign s2_hit = s2_vld_q && s2_act_q && (s2_sum_q < 19'(RADIUS_SQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_act_q <= 1'b0;
            s1_adx_q <= '0;
            s1_ady_q <= '0;
            s2_vld_q <= 1'b0;
            s2_idx_q <= '0;
            s2_act_q <= 1'b0;
            s2_sum_q <= '0;
        end else begin
            s1_vld_q <= issue;
            if (issue) begin
                s1_idx_q <= cnt_q;
                s1_act_q <= snap_act_q[cnt_q];
                s1_adx_q <= adx;
                s1_ady_q <= ady;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_idx_q <= s1_idx_q;
                s2_act_q <= s1_act_q;
                s2_sum_q <= sum_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow accumulation and result publication
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (accept) begin
            shadow_q <= '0;
        end else if (s2_hit) begin
            shadow_q[s2_idx_q] <= 1'b1;
        end
    end

    always_comb begin
        first_d = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
            if (shadow_q[i] && !found) begin
                first_d = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= '0;
            any_hit_q <= 1'b0;
            first_q   <= '0;
        end else begin
            // busy trails the state by one edge so it rises at T0+1
            busy_q <= (state_q == ISSUE) || (state_q == DRAIN);
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                hit_q     <= shadow_q;
                any_hit_q <= |shadow_q;
                first_q   <= first_d;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.hit           = hit_q;
    assign bus.any_hit       = any_hit_q;
    assign bus.first_hit_idx = first_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Testbench for collision_scheduler: table of directed vectors, randomized
// checks against a distance model, and multi-cycle sequences for held start,
// stray start and reset during a check.
module tb_collision_scheduler;
    logic clk;
    logic rst_n;

    collision_scheduler_if #(.NUM_GHOSTS(4)) bus ();

    collision_scheduler #(
        .NUM_GHOSTS(4),
        .RADIUS_SQ (144)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  px;
        logic [8:0]  py;
        logic [35:0] mx;
        logic [35:0] my;
        logic [3:0]  act;
        logic [3:0]  exp_hit;
        logic        exp_any;
        logic [1:0]  exp_idx;
    } vec_t;

    int         vectors;
    int         miscompares;
    logic [3:0] last_hit;
    vec_t       tbl[8];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Model: plain integer Euclidean distance, squared
    function automatic logic [3:0] ref_hit(input vec_t v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int dx;
            int dy;
            dx = int'(v.px) - int'(v.mx[9*i +: 9]);
            dy = int'(v.py) - int'(v.my[9*i +: 9]);
            if (v.act[i] && (dx * dx + dy * dy < 144)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_first(input logic [3:0] h);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (h[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic int clamp9(input int x);
        if (x < 0) return 0;
        if (x > 511) return 511;
        return x;
    endfunction

    task automatic apply(input vec_t v);
        bus.p_x      = v.px;
        bus.p_y      = v.py;
        bus.m_x_all  = v.mx;
        bus.m_y_all  = v.my;
        bus.m_active = v.act;
    endtask

    task automatic scramble();
        bus.p_x      = 9'($urandom);
        bus.p_y      = 9'($urandom);
        bus.m_x_all  = {4'($urandom), 32'($urandom)};
        bus.m_y_all  = {4'($urandom), 32'($urandom)};
        bus.m_active = 4'($urandom);
    endtask

    // One complete check: latency, busy window, result hold, results,
    // single-cycle done; optional stray starts while busy/in DONE.
    task automatic do_check(input vec_t v, input string name, input bit stray);
        int lat;
        bit busy_ok;
        bit hold_ok;
        bit quiet_ok;
        @(negedge clk);
        apply(v);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        busy_ok = (bus.busy === 1'b0);
        hold_ok = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 12; k++) begin
            if (stray && (k == 4 || k == 7)) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (k <= 7) busy_ok &= (bus.busy === (k < 7));
            if (k <= 6) hold_ok &= (bus.hit === last_hit);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({name, " latency"}, lat, 7);
        chk({name, " busy"}, busy_ok, 1);
        chk({name, " hold"}, hold_ok, 1);
        chk({name, " hit"}, bus.hit, v.exp_hit);
        chk({name, " any_hit"}, bus.any_hit, v.exp_any);
        chk({name, " first_idx"}, bus.first_hit_idx, v.exp_idx);
        last_hit = v.exp_hit;
        @(posedge clk);
        #1;
        chk({name, " done_width"}, bus.done, 0);
        if (stray) begin
            quiet_ok = 1'b1;
            repeat (10) begin
                @(posedge clk);
                #1;
                quiet_ok &= (bus.done === 1'b0) && (bus.busy === 1'b0);
            end
            chk({name, " stray_ignored"}, quiet_ok, 1);
        end
    endtask

    initial begin
        vec_t       v;
        vec_t       va;
        vec_t       vb;
        logic [31:0] done_mask;
        logic [3:0]  hit7;
        logic [3:0]  hit15;
        bit          ok;

        vectors     = 0;
        miscompares = 0;
        last_hit    = '0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.p_x     = '0;
        bus.p_y     = '0;
        bus.m_x_all = '0;
        bus.m_y_all = '0;
        bus.m_active = '0;

        //         px      py      mx (g3,g2,g1,g0)                     my (g3,g2,g1,g0)                     act      hit      any   idx
        tbl[0] = '{9'd100, 9'd100, {9'd300, 9'd108, 9'd112, 9'd100}, {9'd300, 9'd108, 9'd100, 9'd111}, 4'b1111, 4'b0101, 1'b1, 2'd0};
        tbl[1] = '{9'd0,   9'd0,   {9'd400, 9'd300, 9'd200, 9'd511}, {9'd400, 9'd300, 9'd200, 9'd511}, 4'b1111, 4'b0000, 1'b0, 2'd0};
        tbl[2] = '{9'd50,  9'd50,  {9'd50,  9'd50,  9'd50,  9'd50 }, {9'd50,  9'd50,  9'd50,  9'd50 }, 4'b1010, 4'b1010, 1'b1, 2'd1};
        tbl[3] = '{9'd20,  9'd20,  {9'd9,   9'd8,   9'd20,  9'd31 }, {9'd20,  9'd20,  9'd32,  9'd20 }, 4'b1111, 4'b1001, 1'b1, 2'd0};
        tbl[4] = '{9'd511, 9'd0,   {9'd500, 9'd505, 9'd511, 9'd0  }, {9'd5,   9'd3,   9'd0,   9'd511}, 4'b0101, 4'b0100, 1'b1, 2'd2};
        tbl[5] = '{9'd7,   9'd7,   {9'd7,   9'd7,   9'd7,   9'd7  }, {9'd7,   9'd7,   9'd7,   9'd7  }, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[6] = '{9'd100, 9'd100, {9'd92,  9'd400, 9'd400, 9'd400}, {9'd92,  9'd0,   9'd0,   9'd0  }, 4'b1000, 4'b1000, 1'b1, 2'd3};
        tbl[7] = '{9'd511, 9'd511, {9'd504, 9'd511, 9'd0,   9'd500}, {9'd504, 9'd499, 9'd0,   9'd511}, 4'b1110, 4'b1000, 1'b1, 2'd3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset hit", bus.hit, 0);
        chk("reset any_hit", bus.any_hit, 0);
        chk("reset first_idx", bus.first_hit_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_check(tbl[i], $sformatf("tbl%0d", i), i == 3);
        end

        for (int n = 0; n < 30; n++) begin
            int px;
            int py;
            px = int'($urandom_range(0, 511));
            py = int'($urandom_range(0, 511));
            v.px = 9'(px);
            v.py = 9'(py);
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 3) != 0) begin
                    v.mx[9*g +: 9] = 9'(clamp9(px + int'($urandom_range(0, 30)) - 15));
                    v.my[9*g +: 9] = 9'(clamp9(py + int'($urandom_range(0, 30)) - 15));
                end else begin
                    v.mx[9*g +: 9] = 9'($urandom);
                    v.my[9*g +: 9] = 9'($urandom);
                end
            end
            v.act     = 4'($urandom);
            v.exp_hit = ref_hit(v);
            v.exp_any = |v.exp_hit;
            v.exp_idx = ref_first(v.exp_hit);
            do_check(v, $sformatf("rand%0d", n), 1'b0);
        end

        // start held high for 16 edges: accepted at T0 and T0+8 only;
        // inputs switched at T0+2 must land in the second check, not the first
        va = tbl[0];
        vb = tbl[2];
        done_mask = '0;
        hit7  = '0;
        hit15 = '0;
        @(negedge clk);
        apply(va);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_mask[k] = 1'b1;
            if (k == 7) hit7 = bus.hit;
            if (k == 15) hit15 = bus.hit;
            if (k == 2) apply(vb);
            if (k == 15) bus.start = 1'b0;
        end
        chk("held done_pattern", done_mask, 32'h0000_8080);
        chk("held first_result", hit7, va.exp_hit);
        chk("held second_result", hit15, vb.exp_hit);
        last_hit = vb.exp_hit;

        // Reset asserted at T0+3 aborts the check
        @(negedge clk);
        apply(tbl[0]);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort hit", bus.hit, 0);
        chk("abort any_hit", bus.any_hit, 0);
        chk("abort done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            ok &= (bus.done === 1'b0) && (bus.hit === 4'b0000) && (bus.busy === 1'b0);
        end
        chk("abort no_done", ok, 1);
        last_hit = '0;
        do_check(tbl[6], "post_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
